// File: rtl/hex_round_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : hex_round_pipe
//  Description : Three-stage, back-pressured hex cube-coordinate rounder.
//                Rounds BATCH lanes of fixed-point (q,r,s) to the nearest hex
//                cell, restores q+r+s=0, saturates to OW bits and computes
//                the saturated hex distance to a per-batch centre cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_round_pipe #(
    parameter int BATCH = 10,
    parameter int IW    = 32,
    parameter int FRAC  = 16,
    parameter int OW    = 16,
    parameter int DW    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BATCH*IW-1:0]   q_f,
    input  logic [BATCH*IW-1:0]   r_f,
    input  logic [BATCH*IW-1:0]   s_f,
    input  logic [OW-1:0]         ctr_q,
    input  logic [OW-1:0]         ctr_r,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BATCH*OW-1:0]   q,
    output logic [BATCH*OW-1:0]   r,
    output logic [BATCH*OW-1:0]   s,
    output logic [BATCH*DW-1:0]   depth,
    output logic [BATCH-1:0]      ovf,
    output logic                  ovf_sticky
);

    // Widths: rounding sum/error, rounded integer, constraint fix, depth math
    localparam int c_EW  = IW + 1;
    localparam int c_XW  = IW - FRAC + 1;
    localparam int c_FW  = IW - FRAC + 2;
    localparam int c_DXW = OW + 2;

    localparam logic [c_EW-1:0] c_HALF  = {{IW{1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic [c_EW-1:0] c_LMASK = ({{IW{1'b0}}, 1'b1} << FRAC) - c_EW'(1);

    localparam logic signed [c_FW-1:0] c_OMAX = $signed({{(c_FW-OW+1){1'b0}}, {(OW-1){1'b1}}});
    localparam logic signed [c_FW-1:0] c_OMIN = $signed({{(c_FW-OW+1){1'b1}}, {(OW-1){1'b0}}});

    // x + 0.5 in IW+1 bits so inputs near the positive limit do not wrap
    function automatic logic [c_EW-1:0] round_sum(input logic [IW-1:0] x);
        return {x[IW-1], x} + c_HALF;
    endfunction

    // floor((x + 0.5)): dropping the fraction bits of a two's complement sum
    function automatic logic [c_XW-1:0] round_int(input logic [IW-1:0] x);
        logic [c_EW-1:0] t;
        t = round_sum(x);
        return t[IW:FRAC];
    endfunction

    // |round(x) * 2^FRAC - x|
    function automatic logic [c_EW-1:0] round_err(input logic [IW-1:0] x);
        logic [c_EW-1:0] t;
        logic [c_EW-1:0] d;
        t = round_sum(x);
        d = (t & ~c_LMASK) - {x[IW-1], x};
        return d[IW] ? -d : d;
    endfunction

    // Clamp to the signed OW range; MSB of the result flags a clamp
    function automatic logic [OW:0] sat_c(input logic signed [c_FW-1:0] v);
        if (v > c_OMAX)      return {1'b1, c_OMAX[OW-1:0]};
        else if (v < c_OMIN) return {1'b1, c_OMIN[OW-1:0]};
        else                 return {1'b0, v[OW-1:0]};
    endfunction

    function automatic logic [c_DXW-1:0] abs_d(input logic [c_DXW-1:0] v);
        return v[c_DXW-1] ? -v : v;
    endfunction

    // ------------------------------------------------------------------
    // Flow control: the whole pipe moves together or holds together
    // ------------------------------------------------------------------
    logic r_v1, r_v2, r_v3;
    logic w_adv, w_ld1, w_ld2, w_ld3;
    logic [OW-1:0] r_s1_cq, r_s1_cr, r_s2_cq, r_s2_cr;
    logic r_sticky;

    assign w_adv     = !r_v3 || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v3;
    assign w_ld1     = w_adv && in_valid;
    assign w_ld2     = w_adv && r_v1;
    assign w_ld3     = w_adv && r_v2;

    // Stage valid bits; a reset drops every in-flight batch at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    // Centre cell rides alongside its batch through S1 and S2
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_cq <= '0;
            r_s1_cr <= '0;
            r_s2_cq <= '0;
            r_s2_cr <= '0;
        end else begin
            if (w_ld1) begin
                r_s1_cq <= ctr_q;
                r_s1_cr <= ctr_r;
            end
            if (w_ld2) begin
                r_s2_cq <= r_s1_cq;
                r_s2_cr <= r_s1_cr;
            end
        end
    end

    // Sticky overflow latches once an overflowing batch has been presented
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_sticky <= 1'b0;
        else if (r_v3 && (|ovf))
            r_sticky <= 1'b1;
    end

    assign ovf_sticky = r_sticky || (r_v3 && (|ovf));

    // Centre in depth-math width, shared by all lanes
    logic [c_DXW-1:0] w_cq3x, w_cr3x, w_cs3x;
    assign w_cq3x = {{2{r_s2_cq[OW-1]}}, r_s2_cq};
    assign w_cr3x = {{2{r_s2_cr[OW-1]}}, r_s2_cr};
    assign w_cs3x = -w_cq3x - w_cr3x;

    // ------------------------------------------------------------------
    // Per-lane datapath
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < BATCH; gi++) begin : g_lane
        logic [IW-1:0]            w_qf, w_rf, w_sf;
        logic [c_XW-1:0]          r_s1_qi, r_s1_ri, r_s1_si;
        logic [c_EW-1:0]          r_s1_qe, r_s1_re, r_s1_se;
        logic signed [c_FW-1:0]   w_qx, w_rx, w_sx, w_qn, w_rn, w_sn;
        logic [OW:0]              w_qs, w_rs, w_ss;
        logic [OW-1:0]            r_s2_q, r_s2_r, r_s2_s;
        logic                     r_s2_ovf;
        logic [c_DXW-1:0]         w_aq, w_ar, w_as, w_dmax;
        logic [DW-1:0]            w_dep;
        logic [OW-1:0]            r_s3_q, r_s3_r, r_s3_s;
        logic [DW-1:0]            r_s3_depth;
        logic                     r_s3_ovf;

        assign w_qf = q_f[gi*IW +: IW];
        assign w_rf = r_f[gi*IW +: IW];
        assign w_sf = s_f[gi*IW +: IW];

        // S1: round each component and keep its rounding error
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_s1_qi <= '0;
                r_s1_ri <= '0;
                r_s1_si <= '0;
                r_s1_qe <= '0;
                r_s1_re <= '0;
                r_s1_se <= '0;
            end else if (w_ld1) begin
                r_s1_qi <= round_int(w_qf);
                r_s1_ri <= round_int(w_rf);
                r_s1_si <= round_int(w_sf);
                r_s1_qe <= round_err(w_qf);
                r_s1_re <= round_err(w_rf);
                r_s1_se <= round_err(w_sf);
            end
        end

        assign w_qx = {r_s1_qi[c_XW-1], r_s1_qi};
        assign w_rx = {r_s1_ri[c_XW-1], r_s1_ri};
        assign w_sx = {r_s1_si[c_XW-1], r_s1_si};

        // Rebuild the component with the largest error; ties fall to s, then r
        always_comb begin
            w_qn = w_qx;
            w_rn = w_rx;
            w_sn = w_sx;
            if ((r_s1_qe > r_s1_re) && (r_s1_qe > r_s1_se))
                w_qn = -w_rx - w_sx;
            else if (r_s1_re > r_s1_se)
                w_rn = -w_qx - w_sx;
            else
                w_sn = -w_qx - w_rx;
        end

        assign w_qs = sat_c(w_qn);
        assign w_rs = sat_c(w_rn);
        assign w_ss = sat_c(w_sn);

        // S2: register the fixed and clamped coordinates
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_s2_q   <= '0;
                r_s2_r   <= '0;
                r_s2_s   <= '0;
                r_s2_ovf <= 1'b0;
            end else if (w_ld2) begin
                r_s2_q   <= w_qs[OW-1:0];
                r_s2_r   <= w_rs[OW-1:0];
                r_s2_s   <= w_ss[OW-1:0];
                r_s2_ovf <= w_qs[OW] | w_rs[OW] | w_ss[OW];
            end
        end

        assign w_aq = abs_d({{2{r_s2_q[OW-1]}}, r_s2_q} - w_cq3x);
        assign w_ar = abs_d({{2{r_s2_r[OW-1]}}, r_s2_r} - w_cr3x);
        assign w_as = abs_d({{2{r_s2_s[OW-1]}}, r_s2_s} - w_cs3x);

        // Hex distance is the largest of the three axis offsets
        always_comb begin
            w_dmax = w_aq;
            if (w_ar > w_dmax) w_dmax = w_ar;
            if (w_as > w_dmax) w_dmax = w_as;
        end

        if (DW < c_DXW) begin : g_sat
            localparam logic [c_DXW-1:0] c_DMAX = {{(c_DXW-DW){1'b0}}, {DW{1'b1}}};
            assign w_dep = (w_dmax > c_DMAX) ? {DW{1'b1}} : w_dmax[DW-1:0];
        end else begin : g_nosat
            assign w_dep = DW'(w_dmax);
        end

        // S3: output registers, held while the consumer stalls
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_s3_q     <= '0;
                r_s3_r     <= '0;
                r_s3_s     <= '0;
                r_s3_depth <= '0;
                r_s3_ovf   <= 1'b0;
            end else if (w_ld3) begin
                r_s3_q     <= r_s2_q;
                r_s3_r     <= r_s2_r;
                r_s3_s     <= r_s2_s;
                r_s3_depth <= w_dep;
                r_s3_ovf   <= r_s2_ovf;
            end
        end

        assign q[gi*OW +: OW]     = r_s3_q;
        assign r[gi*OW +: OW]     = r_s3_r;
        assign s[gi*OW +: OW]     = r_s3_s;
        assign depth[gi*DW +: DW] = r_s3_depth;
        assign ovf[gi]            = r_s3_ovf;
    end

endmodule
`default_nettype wire

// File: doc/hex_round_pipe.md
Name: hex_round_pipe

Overview:
- Pipelined, back-pressured successor to the single-cycle hex cube-coordinate rounder.
- Takes BATCH lanes of fixed-point cube coordinates (q,r,s) and rounds each lane to the nearest hex cell. Re-establishes q+r+s=0 by fixing the component with the largest rounding error.
- Computes per-lane hex depth (distance from a programmable centre cell), saturated to DW bits. Flags lanes whose rounded coordinate overflows OW bits.
- Sits between the transform stage and the tile binner; valid/ready on both sides.

Parameters:
BATCH, 10, number of parallel lanes
IW, 32, input coordinate width (signed fixed point)
FRAC, 16, fractional bits of the input (1 <= FRAC < IW)
OW, 16, signed output coordinate width (OW <= IW-FRAC+1)
DW, 8, unsigned depth width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  input batch valid
in_ready  out  1  block can accept a batch this cycle
q_f, r_f, s_f  in  BATCH x IW  signed Q(IW-FRAC).FRAC cube coords per lane
ctr_q, ctr_r  in  OW each  signed centre cell for depth; sampled with the batch on acceptance
out_valid  out  1  output batch valid
out_ready  in  1  downstream accepts
q, r, s  out  BATCH x OW  signed rounded cube coords
depth  out  BATCH x DW  hex distance to centre, saturated
ovf  out  BATCH x 1  lane coordinate saturated
ovf_sticky  out  1  OR of all ovf since reset

Behaviour:
- Reset (async, active-high): all stage valids 0, out_valid=0, ovf_sticky=0. q/r/s/depth/ovf=0. in_ready=1 once reset deasserts.
- Pipeline and latency:
  - Three register stages; a batch accepted in cycle N appears on out_valid in cycle N+3 with no stall.
  - S1 rounds and takes errors. S2 fixes the largest error and saturates. S3 computes depth and registers outputs.
- Flow control:
  - advance = !out_valid || out_ready. in_ready = advance; combinational from out_ready.
  - All stages shift when advance=1, else all hold. Bubbles propagate as invalid stages.
  - Accept iff in_valid && in_ready; batches are never dropped or duplicated.
  - Output data stays stable while out_valid && !out_ready.
- Rounding per component x:
  - xi = floor((x + 2^(FRAC-1)) / 2^FRAC), computed in IW+1 bits so x near max does not wrap (round half up).
  - Error e = |xi*2^FRAC - x|, IW+1 bits unsigned.
- Constraint fix (in order):
  - If eq>er and eq>es, then q = -r-s.
  - Else if er>es, then r = -q-s.
  - Else s = -q-r.
  - Ties therefore favour fixing s, then r. Arithmetic is in IW-FRAC+2 bits.
- Saturation:
  - Each fixed component is clamped to [-2^(OW-1), 2^(OW-1)-1]; ovf[i]=1 if any of the three clamped.
  - After clamping, s output = -q-r is not re-enforced; ovf marks the lane invalid for the constraint.
- Depth:
  - cs = -ctr_q-ctr_r. depth = max(|q-ctr_q|, |r-ctr_r|, |s-cs|), computed in OW+2 bits.
  - Clamped to 2^DW-1.
  - Centre values travel with their batch through the pipe.
- ovf_sticky sets when a batch with any ovf lane is presented at the output with out_valid; it clears only on reset.
- Reset mid-operation: all in-flight batches are discarded and out_valid drops immediately (asynchronously).

Test Plan:
- Exact integers q_f=0x00030000, r_f=0xFFFE0000, s_f=0xFFFF0000, centre (0,0) -> cycle N+3: q=3, r=-2, s=-1, depth=3, ovf=0.
- Fix-r case q_f=0x00016666, r_f=0xFFFF6667, s_f=0xFFFF3334 (errors 0x6666/0x6667/0x3334) -> q=1, r=0, s=-1, depth=1.
- Overflow q_f=0x7FFF8000, r_f=0x80008000, s_f=0 (OW=16):
  - No IW wrap. q clamps to 32767, r clamps to -32768, ovf=1, ovf_sticky=1 after output.
- Depth saturation (300,-150,-150) exact, centre (0,0), DW=8 -> depth=255, ovf=0. Same coordinates with centre (100,-50) -> depth=200.
- Back-pressure: in_valid=1 with distinct batches each cycle, out_ready=0 for cycles 4-8:
  - in_ready=0 throughout the stall.
  - Exactly three batches are buffered, then drain in order with none lost or repeated.
- Reset asserted while 2 batches are in flight -> out_valid=0 immediately. After release the first new batch emerges 3 cycles after its acceptance and ovf_sticky=0.
